// File: rtl/zap_wb_walk_arbiter.sv
// Shares the single memory-side Wishbone port between the page walker (M0) and the cache FSM (M1).
// Optional watchdog/abort path is compiled in when ZAP_WB_ARB_TIMEOUT_EN is defined.
module zap_wb_walk_arbiter #(
    parameter int MAX_CONSEC     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_wen,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_wen,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_rd_dat,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_state
);

    localparam int CW = $clog2(MAX_CONSEC + 1);

    // Handshake: a master owns the bus from the cycle its CYC is granted until it drops CYC;
    // each STB beat completes on the cycle i_wb_ack is high, and that ACK goes only to the owner.
`ifdef ZAP_WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2,
        ABORT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] consec;
    logic [CW-1:0] consec_nxt;

`ifdef ZAP_WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wdog;
    logic            in_gnt;
    logic            own_stb;
    logic            wd_expired;
    logic            abort_m1;

    assign in_gnt     = (state == GNT_M0) || (state == GNT_M1);
    assign own_stb    = (state == GNT_M1) ? i_m1_stb : i_m0_stb;
    // Fires on the TIMEOUT_CYCLES-th consecutive stalled strobe cycle.
    assign wd_expired = in_gnt && own_stb && !i_wb_ack
                        && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wdog     <= '0;
            abort_m1 <= 1'b0;
        end else begin
            if (in_gnt && (state_nxt == state)) begin
                if (i_wb_ack) begin
                    wdog <= '0;
                end else if (own_stb) begin
                    wdog <= wdog + WD_W'(1);
                end
            end else begin
                wdog <= '0;
            end
            if ((state_nxt == ABORT) && (state != ABORT)) begin
                abort_m1 <= (state == GNT_M1);
            end
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            consec <= '0;
        end else begin
            state  <= state_nxt;
            consec <= consec_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        consec_nxt = consec;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_wen   = 1'b0;
        o_wb_sel   = 4'h0;
        o_wb_adr   = 32'h0;
        o_wb_dat   = 32'h0;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m1_err   = 1'b0;
        o_gnt      = 2'b00;
        case (state)
            IDLE: begin
                // consec counts M0 wins that made a waiting M1 lose; at the limit M1 goes first.
                if (i_m0_cyc && i_m1_cyc) begin
                    if (consec == CW'(MAX_CONSEC)) begin
                        state_nxt  = GNT_M1;
                        consec_nxt = '0;
                    end else begin
                        state_nxt  = GNT_M0;
                        consec_nxt = consec + CW'(1);
                    end
                end else if (i_m0_cyc) begin
                    state_nxt  = GNT_M0;
                    consec_nxt = '0;
                end else if (i_m1_cyc) begin
                    state_nxt  = GNT_M1;
                    consec_nxt = '0;
                end
            end
            GNT_M0: begin
                o_wb_cyc = i_m0_cyc;
                o_wb_stb = i_m0_stb;
                o_wb_wen = i_m0_wen;
                o_wb_sel = i_m0_sel;
                o_wb_adr = i_m0_adr;
                o_wb_dat = i_m0_dat;
                o_m0_ack = i_wb_ack;
                o_gnt    = 2'b01;
                if (!i_m0_cyc) begin
                    state_nxt = IDLE;
                end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    o_m0_err  = 1'b1;
                    state_nxt = ABORT;
                end
`endif
            end
            GNT_M1: begin
                o_wb_cyc = i_m1_cyc;
                o_wb_stb = i_m1_stb;
                o_wb_wen = i_m1_wen;
                o_wb_sel = i_m1_sel;
                o_wb_adr = i_m1_adr;
                o_wb_dat = i_m1_dat;
                o_m1_ack = i_wb_ack;
                o_gnt    = 2'b10;
                if (!i_m1_cyc) begin
                    state_nxt = IDLE;
                end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    o_m1_err  = 1'b1;
                    state_nxt = ABORT;
                end
`endif
            end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
            ABORT: begin
                // Bus stays parked and late ACKs are swallowed until the aborted owner lets go.
                o_gnt = abort_m1 ? 2'b10 : 2'b01;
                if (!(abort_m1 ? i_m1_cyc : i_m0_cyc)) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_rd_dat = i_wb_dat;
    assign o_state  = state;

endmodule
